// File: rtl/matmul_result_drain.sv
// Snapshots the MATMUL result on done, requantizes the m x p region and streams it row-major.
// First element one cycle after the capture edge; data/row/col/last hold while out_valid && !out_ready.
module matmul_result_drain #(
    parameter int BITS = 8,
    parameter int DIM  = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                done,
    input  logic [$clog2(DIM):0]                m,
    input  logic [$clog2(DIM):0]                p,
    input  logic [3:0]                          shift,
    input  logic [DIM-1:0][DIM-1:0][2*BITS-1:0] dataIn,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [BITS-1:0]                     out_data,
    output logic [$clog2(DIM)-1:0]              out_row,
    output logic [$clog2(DIM)-1:0]              out_col,
    output logic                                out_last,
    output logic                                busy,
    output logic                                drain_done,
    output logic                                overrun
);
    localparam int IW = $clog2(DIM);
    localparam int SW = 2*BITS + 1;
    localparam logic [IW:0] DIM_W = (IW+1)'(DIM);
    localparam logic [IW:0] ONE_W = (IW+1)'(1);

    typedef enum logic [1:0] {IDLE, DRAIN, FIN} state_t;

    state_t                              state;
    logic [DIM-1:0][DIM-1:0][2*BITS-1:0] snap;
    logic [IW:0]                         rows;
    logic [IW:0]                         cols;
    logic [3:0]                          shamt;
    logic                                accept;
    logic [IW:0]                         m_clamp;
    logic [IW:0]                         p_clamp;
    logic [IW-1:0]                       nxt_row;
    logic [IW-1:0]                       nxt_col;
    logic                                nxt_last;

    // Sum is one bit wider than the element so the rounding add cannot wrap.
    function automatic logic [BITS-1:0] requant(input logic [2*BITS-1:0] v,
                                                input logic [3:0]        sh);
        logic [SW-1:0] t;
        t = {1'b0, v};
        if (sh != 4'd0)
            t = (t + (SW'(1) << (sh - 4'd1))) >> sh;
        requant = (t > SW'((1 << BITS) - 1)) ? '1 : t[BITS-1:0];
    endfunction

    assign m_clamp = (m > DIM_W) ? DIM_W : m;
    assign p_clamp = (p > DIM_W) ? DIM_W : p;
    assign accept  = done && (state != DRAIN) && (m != '0) && (p != '0);

    always_comb begin
        nxt_row = out_row;
        nxt_col = out_col + 1'b1;
        if ({1'b0, out_col} == cols - ONE_W) begin
            nxt_col = '0;
            nxt_row = out_row + 1'b1;
        end
        nxt_last = ({1'b0, nxt_row} == rows - ONE_W) && ({1'b0, nxt_col} == cols - ONE_W);
    end

    // The snapshot needs no reset; it is only read after a capture.
    always_ff @(posedge clk) begin
        if (accept)
            snap <= dataIn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            drain_done <= 1'b0;
            overrun    <= 1'b0;
            rows       <= '0;
            cols       <= '0;
            shamt      <= '0;
        end else begin
            drain_done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    state <= IDLE;
                    if (accept) begin
                        state     <= DRAIN;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        rows      <= m_clamp;
                        cols      <= p_clamp;
                        shamt     <= shift;
                        out_data  <= requant(dataIn[0][0], shift);
                        out_row   <= '0;
                        out_col   <= '0;
                        out_last  <= (m_clamp == ONE_W) && (p_clamp == ONE_W);
                    end
                end
                DRAIN: begin
                    if (done)
                        overrun <= 1'b1;
                    // out_valid is always high in DRAIN, so out_ready alone means a transfer.
                    if (out_ready) begin
                        if (out_last) begin
                            state      <= FIN;
                            busy       <= 1'b0;
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            drain_done <= 1'b1;
                        end else begin
                            out_row  <= nxt_row;
                            out_col  <= nxt_col;
                            out_last <= nxt_last;
                            out_data <= requant(snap[nxt_row][nxt_col], shamt);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/matmul_result_drain.md
Name: matmul_result_drain

Overview:
- Downstream consumer of the MATMUL systolic array.
- On MATMUL's done pulse it snapshots the DIM x DIM result array (2*BITS per element) and requantizes the active m x p region to BITS-wide pixels: round, shift, saturate.
- Streams the pixels out row-major over a valid/ready handshake to the feature-map writeback buffer.
- Frees MATMUL to start the next tile while the drain is in progress.

Parameters:
- BITS, 8, pixel width of the output stream (MATMUL input width).
- DIM, 32, maximum feature-map dimension; the result array is DIM x DIM.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- done  in  1  MATMUL completion pulse; result is valid in this cycle
- m  in  $clog2(DIM)+1  result rows
- p  in  $clog2(DIM)+1  result columns
- shift  in  4  right-shift amount for requantization, 0..15
- dataIn  in  [DIM-1:0][DIM-1:0] x 2*BITS  MATMUL dataOut, unsigned
- out_valid  out  1  stream element valid
- out_ready  in  1  downstream accepts the element
- out_data  out  BITS  requantized pixel
- out_row  out  $clog2(DIM)  row index of out_data
- out_col  out  $clog2(DIM)  column index of out_data
- out_last  out  1  high with the final element (m-1, p-1)
- busy  out  1  high in DRAIN
- drain_done  out  1  one-cycle pulse after the last element is accepted
- overrun  out  1  sticky error flag

Behaviour:
- Reset values: out_valid, out_data, out_row, out_col, out_last, busy, drain_done and overrun are all 0. State is IDLE. Snapshot buffer contents are don't-care.
- Reset mid-operation: an asynchronous assert drops out_valid at once and returns to IDLE. The partial stream is abandoned.
- States: IDLE, DRAIN, FIN.
- IDLE transitions:
  - done=1, m!=0, p!=0: capture dataIn, m, p and shift into internal registers, then go to DRAIN.
  - m or p above DIM: clamp to DIM at capture.
  - done=1 with m==0 or p==0: ignored, no output, no drain_done.
- Latency: done sampled at edge N gives out_valid=1 with element (0,0) from edge N+1.
- DRAIN handshake:
  - Element (r,c) is presented with out_row=r and out_col=c.
  - Transfer occurs on any edge with out_valid && out_ready.
  - When out_valid && !out_ready, out_data, out_row, out_col and out_last hold stable.
  - out_valid never deasserts without a transfer.
  - After a transfer the next element appears on the next cycle, giving 1 element per cycle at full throughput.
  - Ordering: c increments; at c==p-1, c wraps to 0 and r increments.
  - out_last=1 only with (m-1, p-1).
  - On the transfer of the last element: out_valid goes to 0 and the state goes to FIN.
- FIN: drain_done=1 for exactly one cycle, then IDLE. A done arriving in FIN is treated as in IDLE, so back-to-back tiles are accepted.
- busy=1 in DRAIN only.
- done=1 while in DRAIN: ignored, the snapshot is untouched, and overrun is set to 1. overrun stays 1 until rst.
- Requantization of element v (unsigned, 2*BITS bits):
  - shift==0: t = v.
  - shift>0: t = (v + 2^(shift-1)) >> shift. The sum is computed in 2*BITS+1 bits, so there is no wrap.
  - out_data = t if t <= 2^BITS-1, otherwise 2^BITS-1 (saturate).
- Elements outside the m x p region are never emitted.
- dataIn may change freely after the capture edge.

Test Plan:
- Basic drain: m=2, p=3, shift=0, row0 = 1,2,3, row1 = 4,5,6, out_ready=1 always, done pulse at cycle 0 -> out_valid from cycle 1 to cycle 6 with data 1,2,3,4,5,6 and (row,col) (0,0)..(1,2). out_last only on 6. drain_done pulses at cycle 7. busy high for cycles 1-6.
- Rounding and saturation: m=1, p=4, shift=1, values 300, 301, 511, 600 -> 150, 151, 255, 255. Then shift=0 with values 1000, 255 -> 255, 255.
- Backpressure: 2x2 tile with out_ready toggling 1,0,0,1,... -> data, row and col held stable while out_ready=0. Exactly 4 transfers in order, no duplicates or drops. drain_done follows the 4th transfer.
- Overrun and bounds: second done during a 5x5 drain -> output stream unchanged (25 elements), overrun=1 stays set. Then done with m=0 -> no output, busy stays 0. Then m=40 -> clamped to 32 rows.
- Reset mid-drain: assert rst after 3 transfers of a 4x4 tile -> out_valid=0 and overrun=0 immediately. A new 1x1 tile (value 42) after release -> single element 42 with out_last=1.
- Back-to-back: done in the FIN cycle of a 1x2 tile -> the second tile's first element appears on the next cycle, no element lost.
